// File: rtl/fetch_stage.sv
// fetch_stage: PC register, 1-cycle synchronous imem read, and a small
// credit-controlled output FIFO feeding decode over valid/ready.
`default_nettype none

module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_out,
  input  logic            ready_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   req_pc_q;
  logic              inflight_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [2*XLEN-1:0] mem_q [DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       credit;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    valid_out = (count_q != '0) && !redirect_valid;
    pop       = valid_out && ready_out;
    push      = inflight_q && !redirect_valid;
    // Slots already committed: buffered words plus the read still in flight.
    credit    = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = !reset && !redirect_valid && (credit < (CW+1)'(DEPTH));
    imem_req  = issue;
    imem_addr = pc_q;
    pc_out    = '0;
    instr_out = '0;
    if (count_q != '0) begin
      pc_out    = mem_q[rd_ptr_q][2*XLEN-1:XLEN];
      instr_out = mem_q[rd_ptr_q][XLEN-1:0];
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + XLEN'(4);
        req_pc_q <= pc_q;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_pc_q, imem_rdata};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (count_q != CW'(DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency, backpressure, redirect, PC wrap, async reset.
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_rdata = '0;
  logic        ready_out = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  logic        w_redir = 1'b0;
  logic [31:0] w_redir_pc = '0;
  logic        w_ready = 1'b1;
  logic [31:0] w_rdata = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .valid_out(valid_out), .ready_out(ready_out), .pc_out(pc_out), .instr_out(instr_out)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .valid_out(w_valid), .ready_out(w_ready), .pc_out(w_pc), .instr_out(w_instr)
  );

  // Instruction memory: one-cycle read latency, word = addr ^ A5A5_0000.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
    if (w_req)    w_rdata    <= w_addr ^ 32'hA5A5_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk); #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFF8);

    // Latency and streaming; wrap instance runs alongside
    @(negedge clk); reset = 1'b0; #1;
    chk("t1_req_N", {31'b0, imem_req}, 32'd1);
    chk("t1_addr_N", imem_addr, 32'd0);
    chk("t1_valid_N", {31'b0, valid_out}, 32'd0);
    chk("t1_wreq_N", {31'b0, w_req}, 32'd1);
    @(negedge clk); #1;
    chk("t1_addr_N1", imem_addr, 32'd4);
    chk("t1_valid_N1", {31'b0, valid_out}, 32'd0);
    @(negedge clk); #1;
    chk("t1_valid_N2", {31'b0, valid_out}, 32'd1);
    chk("t1_pc_N2", pc_out, 32'd0);
    chk("t1_instr_N2", instr_out, 32'hA5A5_0000);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", w_instr, 32'h5A5A_FFF8);
    @(negedge clk); #1;
    chk("t1_pc_N3", pc_out, 32'd4);
    chk("t1_instr_N3", instr_out, 32'hA5A5_0004);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_instr1", w_instr, 32'h5A5A_FFFC);
    @(negedge clk); #1;
    chk("t1_pc_N4", pc_out, 32'd8);
    chk("wrap_pc2", w_pc, 32'h0000_0000);
    chk("wrap_instr2", w_instr, 32'hA5A5_0000);
    @(negedge clk); #1;
    chk("t1_pc_N5", pc_out, 32'd12);
    chk("t1_valid_N5", {31'b0, valid_out}, 32'd1);
    chk("wrap_pc3", w_pc, 32'h0000_0004);
    chk("wrap_valid3", {31'b0, w_valid}, 32'd1);

    // Backpressure from N+2 for five cycles
    do_reset();
    chk("t2_addr_N", imem_addr, 32'd0);
    @(negedge clk); #1;
    chk("t2_addr_N1", imem_addr, 32'd4);
    chk("t2_req_N1", {31'b0, imem_req}, 32'd1);
    @(negedge clk); ready_out = 1'b0; #1;
    chk("t2_req_N2", {31'b0, imem_req}, 32'd0);
    chk("t2_pc_N2", pc_out, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t2_hold_req", {31'b0, imem_req}, 32'd0);
      chk("t2_hold_valid", {31'b0, valid_out}, 32'd1);
      chk("t2_hold_pc", pc_out, 32'd0);
      chk("t2_hold_instr", instr_out, 32'hA5A5_0000);
    end
    @(negedge clk); ready_out = 1'b1; #1;
    chk("t2_rel_pc0", pc_out, 32'd0);
    chk("t2_rel_req", {31'b0, imem_req}, 32'd1);
    chk("t2_rel_addr", imem_addr, 32'd8);
    @(negedge clk); #1;
    chk("t2_rel_valid1", {31'b0, valid_out}, 32'd1);
    chk("t2_rel_pc1", pc_out, 32'd4);
    chk("t2_rel_instr1", instr_out, 32'hA5A5_0004);
    @(negedge clk); #1;
    chk("t2_rel_valid2", {31'b0, valid_out}, 32'd1);
    chk("t2_rel_pc2", pc_out, 32'd8);

    // Redirect with a buffered word and a read in flight
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); ready_out = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_1003; #1;
    chk("t3_valid_redir", {31'b0, valid_out}, 32'd0);
    chk("t3_req_redir", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; ready_out = 1'b1; #1;
    chk("t3_addr", imem_addr, 32'h0000_1000);
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    chk("t3_valid_a", {31'b0, valid_out}, 32'd0);
    @(negedge clk); #1;
    chk("t3_valid_b", {31'b0, valid_out}, 32'd0);
    chk("t3_addr_b", imem_addr, 32'h0000_1004);
    @(negedge clk); #1;
    chk("t3_valid_c", {31'b0, valid_out}, 32'd1);
    chk("t3_pc", pc_out, 32'h0000_1000);
    chk("t3_instr", instr_out, 32'hA5A5_1000);

    // Redirect held three cycles
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("t4_req0", {31'b0, imem_req}, 32'd0);
    chk("t4_valid0", {31'b0, valid_out}, 32'd0);
    @(negedge clk); redirect_pc = 32'h200; #1;
    chk("t4_req1", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_pc = 32'h300; #1;
    chk("t4_req2", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("t4_req_resume", {31'b0, imem_req}, 32'd1);
    chk("t4_addr_resume", imem_addr, 32'h300);
    @(negedge clk); #1;
    chk("t4_valid_gap", {31'b0, valid_out}, 32'd0);
    @(negedge clk); #1;
    chk("t4_valid", {31'b0, valid_out}, 32'd1);
    chk("t4_pc", pc_out, 32'h300);
    chk("t4_instr", instr_out, 32'hA5A5_0300);

    // Asynchronous reset mid-cycle with the FIFO full
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); ready_out = 1'b0; #1;
    @(negedge clk); #1;
    chk("t6_full_valid", {31'b0, valid_out}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, valid_out}, 32'd0);
    chk("t6_async_req", {31'b0, imem_req}, 32'd0);
    chk("t6_async_pc", pc_out, 32'd0);
    chk("t6_async_addr", imem_addr, 32'd0);
    @(negedge clk); reset = 1'b0; ready_out = 1'b1; #1;
    chk("t6_M_valid", {31'b0, valid_out}, 32'd0);
    chk("t6_M_addr", imem_addr, 32'd0);
    chk("t6_M_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk); #1;
    chk("t6_M1_valid", {31'b0, valid_out}, 32'd0);
    @(negedge clk); #1;
    chk("t6_M2_valid", {31'b0, valid_out}, 32'd1);
    chk("t6_M2_pc", pc_out, 32'd0);
    @(negedge clk); #1;
    chk("t6_M3_pc", pc_out, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
